// File: rtl/seq_step_ctrl.sv
// seq_step_ctrl: programmable code-table sequencer.
// Holds an 8-entry code table and a sequence length. It steps through the
// table under start/stop/pause control, in continuous or one-shot mode.
// Optional feature: define SEQ_PRESCALE_EN to gate advances with a
// PRESCALE-cycle divider. The default build advances on every non-paused
// RUN cycle.
module seq_step_ctrl #(
    parameter int W     = 3,
    parameter int DEPTH = 8
`ifdef SEQ_PRESCALE_EN
    ,
    parameter int PRESCALE = 4
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_we,
    input  logic [2:0]   cfg_addr,
    input  logic [W-1:0] cfg_data,
    input  logic         cfg_len_we,
    input  logic [3:0]   cfg_len,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         one_shot,
    output logic [W-1:0] q,
    output logic [2:0]   idx,
    output logic         busy,
    output logic         step,
    output logic         done,
    output logic         cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01
    } state_t;

    localparam logic [3:0] MAX_LEN = 4'(DEPTH);
    localparam logic [3:0] RST_LEN = 4'd5;

`ifdef SEQ_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
`endif

    // Power-on contents of the code table: 0 -> 1 -> 3 -> 7 -> 2, rest zero.
    function automatic logic [W-1:0] default_code(input int i);
        case (i)
            1:       return W'(1);
            2:       return W'(3);
            3:       return W'(7);
            4:       return W'(2);
            default: return '0;
        endcase
    endfunction

    state_t       state, state_d;
    logic [W-1:0] tbl [DEPTH];
    logic [3:0]   len, len_d;
    logic         os_q, os_d;
    logic [2:0]   idx_d;
    logic [W-1:0] q_d;
    logic         step_d, done_d, err_d;
    logic         tbl_we;
    logic         adv;
    logic         at_last, out_of_range, len_ok;
    logic [2:0]   idx_next;

`ifdef SEQ_PRESCALE_EN
    logic [PW-1:0] pcnt, pcnt_d;
`endif

    assign at_last      = ({1'b0, idx} == (len - 4'd1));
    assign out_of_range = ({1'b0, idx} >= len);
    assign len_ok       = (cfg_len != 4'd0) && (cfg_len <= MAX_LEN);
    assign idx_next     = at_last ? 3'd0 : idx + 3'd1;
    assign busy         = (state == RUN);

    // State register; any encoding other than IDLE/RUN is recovered by the
    // next-state logic.
    // NOTE: every clocked register uses non-blocking assignment so all flops
    // sample the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // Next-state and next-output decode: stop > start > pause.
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        q_d     = q;
        step_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        os_d    = os_q;
        len_d   = len;
        tbl_we  = 1'b0;
        adv     = 1'b0;
`ifdef SEQ_PRESCALE_EN
        pcnt_d  = pcnt;
`endif
        case (state)
            IDLE: begin
                idx_d  = 3'd0;
                q_d    = tbl[0];
                tbl_we = cfg_we;
                if (cfg_len_we) begin
                    if (len_ok) len_d = cfg_len;
                    else        err_d = 1'b1;
                end
                if (start && !stop) begin
                    state_d = RUN;
                    os_d    = one_shot;
`ifdef SEQ_PRESCALE_EN
                    pcnt_d  = '0;
`endif
                end
            end
            RUN: begin
                err_d = cfg_we || cfg_len_we;
                if (stop) begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                    q_d     = tbl[0];
`ifdef SEQ_PRESCALE_EN
                    pcnt_d  = '0;
`endif
                end else if (!pause) begin
`ifdef SEQ_PRESCALE_EN
                    if (pcnt == PS_LAST) begin
                        pcnt_d = '0;
                        adv    = 1'b1;
                    end else begin
                        pcnt_d = pcnt + 1'b1;
                    end
`else
                    adv = 1'b1;
`endif
                    if (adv) begin
                        if (out_of_range) begin
                            idx_d  = 3'd0;
                            q_d    = tbl[0];
                            step_d = 1'b1;
                        end else if (os_q && at_last) begin
                            state_d = IDLE;
                            idx_d   = 3'd0;
                            q_d     = tbl[0];
                            done_d  = 1'b1;
                        end else begin
                            idx_d  = idx_next;
                            q_d    = tbl[idx_next];
                            step_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
                q_d     = tbl[0];
            end
        endcase
    end

    // Registered outputs and run-mode flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx     <= 3'd0;
            q       <= '0;
            step    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
            os_q    <= 1'b0;
        end else begin
            idx     <= idx_d;
            q       <= q_d;
            step    <= step_d;
            done    <= done_d;
            cfg_err <= err_d;
            os_q    <= os_d;
        end
    end

    // Code table and sequence length; both return to defaults on reset.
    // NOTE: the table is reset explicitly because its power-on contents are
    // part of the block's behaviour, so it must be built from flops rather
    // than a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] <= default_code(i);
            len <= RST_LEN;
        end else begin
            if (tbl_we) tbl[cfg_addr] <= cfg_data;
            len <= len_d;
        end
    end

`ifdef SEQ_PRESCALE_EN
    // Prescale counter: clears on start/stop, holds on pause.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pcnt <= '0;
        else      pcnt <= pcnt_d;
    end
`endif

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Self-checking bench for seq_step_ctrl: directed literal sequences plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_seq_step_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [2:0] cfg_data = '0;
    logic       cfg_len_we = 1'b0;
    logic [3:0] cfg_len = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       one_shot = 1'b0;
    logic [2:0] q;
    logic [2:0] idx;
    logic       busy, step, done, cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    seq_step_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_len_we(cfg_len_we), .cfg_len(cfg_len),
        .start(start), .stop(stop), .pause(pause), .one_shot(one_shot),
        .q(q), .idx(idx), .busy(busy), .step(step), .done(done),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_tbl [8];
    int m_len, m_idx, m_q, m_pc;
    bit m_run, m_os, m_step, m_done, m_err;

    function automatic void m_reset();
        m_tbl = '{0, 1, 3, 7, 2, 0, 0, 0};
        m_len = 5; m_idx = 0; m_q = 0; m_pc = 0;
        m_run = 0; m_os = 0; m_step = 0; m_done = 0; m_err = 0;
    endfunction

    function automatic void m_tick();
        bit legal_len = (cfg_len != 0) && (int'(cfg_len) <= 8);
        bit opp;
        m_step = 0; m_done = 0; m_err = 0;
        if (!m_run) begin
            m_idx = 0;
            m_q   = m_tbl[0];
            if (start && !stop) begin
                m_run = 1; m_os = one_shot; m_pc = 0;
            end
            if (cfg_we) m_tbl[cfg_addr] = int'(cfg_data);
            if (cfg_len_we) begin
                if (legal_len) m_len = int'(cfg_len);
                else           m_err = 1;
            end
        end else begin
            m_err = cfg_we || cfg_len_we;
            if (stop) begin
                m_run = 0; m_idx = 0; m_q = m_tbl[0]; m_pc = 0;
            end else if (!pause) begin
`ifdef SEQ_PRESCALE_EN
                opp  = (m_pc == 3);
                m_pc = (m_pc + 1) % 4;
`else
                opp = 1;
`endif
                if (opp) begin
                    if (m_idx >= m_len) begin
                        m_idx = 0; m_q = m_tbl[0]; m_step = 1;
                    end else if (m_os && m_idx == m_len - 1) begin
                        m_run = 0; m_idx = 0; m_q = m_tbl[0]; m_done = 1;
                    end else begin
                        m_idx = (m_idx + 1) % m_len;
                        m_q = m_tbl[m_idx]; m_step = 1;
                    end
                end
            end
        end
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) m_reset();
            else      m_tick();
        end
    end

    // Per-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("model", {6'd0, q, idx, busy, step, done, cfg_err},
                  {6'd0, 3'(m_q), 3'(m_idx), m_run, m_step, m_done, m_err});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic start_run(input logic os);
        one_shot = os; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int exp_q [7];
        exp_q = '{0, 1, 3, 7, 2, 0, 1};

        tick();
        check("rst_q", q, 0);
        check("rst_busy", {busy, step, done, cfg_err}, 0);
        rst = 1'b1;
        tick();

`ifndef SEQ_PRESCALE_EN
        // Continuous default sequence.
        start_run(1'b0);
        check("cont_q0", q, 0);
        check("cont_load_step", {busy, step}, 2'b10);
        for (int i = 1; i < 7; i++) begin
            tick();
            check("cont_q", q, exp_q[i]);
            check("cont_step", {busy, step}, 2'b11);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_idle", {busy, done, 1'b0, idx}, 0);

        // One-shot default sequence.
        start_run(1'b1);
        check("os_q0", q, 0);
        for (int i = 1; i < 5; i++) begin
            tick();
            check("os_q", q, exp_q[i]);
        end
        tick();
        check("os_done", {done, busy, q, idx}, {1'b1, 1'b0, 3'd0, 3'd0});
        tick();
        check("os_done_pulse", done, 0);

        // Table/length reprogramming, then a write attempt in RUN.
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 3'd5;
        tick();
        cfg_addr = 3'd1; cfg_data = 3'd6; cfg_len_we = 1'b1; cfg_len = 4'd2;
        tick();
        check("cfg_ok0", cfg_err, 0);
        cfg_we = 1'b0; cfg_len_we = 1'b0;
        tick();
        check("cfg_ok1", cfg_err, 0);
        start_run(1'b0);
        check("prog_q", q, 5);
        tick(); check("prog_q", q, 6);
        tick(); check("prog_q", q, 5);
        tick(); check("prog_q", q, 6);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 3'd1;
        tick();
        cfg_we = 1'b0;
        check("run_wr_err", {cfg_err, q}, {1'b1, 3'd5});
        tick(); check("run_wr_q", {cfg_err, q}, {1'b0, 3'd6});
        tick(); check("run_wr_tbl", q, 5);
        stop = 1'b1; tick(); stop = 1'b0;

        // Pause holds the step at q=7.
        async_reset();
        start_run(1'b0);
        tick(); tick(); tick();
        check("pre_pause", q, 7);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_hold", {busy, step, q}, {1'b1, 1'b0, 3'd7});
        end
        pause = 1'b0;
        tick();
        check("pause_release", {step, q}, {1'b1, 3'd2});

        // Stop wins over pause; start with stop stays idle.
        pause = 1'b1; stop = 1'b1; tick(); pause = 1'b0; stop = 1'b0;
        check("stop_pause", {busy, done, 1'b0, idx}, 0);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        check("start_stop", busy, 0);
        tick();
        check("start_stop_hold", busy, 0);

        // Illegal lengths.
        cfg_len_we = 1'b1; cfg_len = 4'd0; tick(); cfg_len_we = 1'b0;
        check("len0_err", cfg_err, 1);
        tick(); check("len0_pulse", cfg_err, 0);
        cfg_len_we = 1'b1; cfg_len = 4'd9; tick(); cfg_len_we = 1'b0;
        check("len9_err", cfg_err, 1);
        start_run(1'b1);
        tick(); tick(); tick(); tick();
        check("len5_last", {done, q}, {1'b0, 3'd2});
        tick();
        check("len5_done", done, 1);

        // Asynchronous reset mid-run restores table and length.
        cfg_we = 1'b1; cfg_addr = 3'd4; cfg_data = 3'd6;
        cfg_len_we = 1'b1; cfg_len = 4'd7;
        tick();
        cfg_we = 1'b0; cfg_len_we = 1'b0;
        start_run(1'b0);
        tick(); tick();
        check("pre_rst_q", q, 3);
        #2 rst = 1'b0;
        #1 check("async_rst", {busy, q, idx}, 0);
        tick();
        rst = 1'b1;
        tick();
        start_run(1'b1);
        tick(); tick(); tick(); tick();
        check("rst_tbl", q, 2);
        tick();
        check("rst_len", done, 1);
`endif

        // Randomized phase against the model.
        for (int i = 0; i < 4000; i++) begin
            start      = ($urandom_range(0, 7) == 0);
            stop       = ($urandom_range(0, 31) == 0);
            pause      = ($urandom_range(0, 5) == 0);
            one_shot   = ($urandom_range(0, 1) == 0);
            cfg_we     = ($urandom_range(0, 15) == 0);
            cfg_addr   = 3'($urandom);
            cfg_data   = 3'($urandom);
            cfg_len_we = ($urandom_range(0, 19) == 0);
            cfg_len    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0) async_reset();
            else tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
